// File: rtl/ball_tracker.sv
// Ball tracker: debounced acquisition, coasting through dropouts, velocity,
// frame watchdog and steering commands from IR sensor-array scan frames.
module ball_tracker #(
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 4,
  parameter int JUMP_MAX    = 2,
  parameter int CENTER_X    = 4,
  parameter int DEADBAND    = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clk_en,
  input  logic       run,
  input  logic       frame_valid,
  input  logic       ball_detected,
  input  logic [3:0] ball_pos_x,
  input  logic [3:0] ball_pos_y,
  output logic [1:0] track_state,
  output logic [3:0] target_x,
  output logic [3:0] target_y,
  output logic [4:0] vel_x,
  output logic [4:0] vel_y,
  output logic       lock,
  output logic       lost,
  output logic       stale,
  output logic       steer_left,
  output logic       steer_right,
  output logic       drive_fwd
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_TRACK  = 2'd2;
  localparam logic [1:0] S_COAST  = 2'd3;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [3:0] ACQ_N  = 4'(ACQ_FRAMES);
  localparam logic [3:0] LOST_N = 4'(LOST_FRAMES);
  localparam logic [4:0] JMAX   = 5'(JUMP_MAX);
  localparam logic signed [4:0] LEFT_TH  = 5'(CENTER_X - DEADBAND);
  localparam logic signed [4:0] RIGHT_TH = 5'(CENTER_X + DEADBAND);

  logic [1:0]      state_reg, state_next;
  logic [3:0]      tx_reg, tx_next, ty_reg, ty_next;
  logic [4:0]      vx_reg, vx_next, vy_reg, vy_next;
  logic [3:0]      hit_reg, hit_next, miss_reg, miss_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            stale_reg, stale_next;
  logic            lock_reg, lock_next, lost_reg, lost_next;

  logic       det;
  logic [4:0] dx, dy, adx, ady;
  logic       jump_ok;

  // Out-of-range coordinates are treated as a miss.
  assign det = ball_detected && (ball_pos_x <= 4'd7) && (ball_pos_y <= 4'd4);
  assign dx  = {1'b0, ball_pos_x} - {1'b0, tx_reg};
  assign dy  = {1'b0, ball_pos_y} - {1'b0, ty_reg};
  assign adx = dx[4] ? (5'd0 - dx) : dx;
  assign ady = dy[4] ? (5'd0 - dy) : dy;
  assign jump_ok = (adx <= JMAX) && (ady <= JMAX);

  always_comb begin
    state_next = state_reg;
    tx_next    = tx_reg;
    ty_next    = ty_reg;
    vx_next    = vx_reg;
    vy_next    = vy_reg;
    hit_next   = hit_reg;
    miss_next  = miss_reg;
    wd_next    = wd_reg;
    stale_next = stale_reg;
    lock_next  = 1'b0;
    lost_next  = 1'b0;
    if (clk_en) begin
      if (frame_valid) begin
        wd_next    = '0;
        stale_next = 1'b0;
        case (state_reg)
          S_SEARCH: if (det) begin
            state_next = S_ACQ;
            hit_next   = 4'd1;
            tx_next    = ball_pos_x;
            ty_next    = ball_pos_y;
            vx_next    = '0;
            vy_next    = '0;
          end
          S_ACQ: begin
            if (!det) begin
              state_next = S_SEARCH;
              hit_next   = '0;
            end else begin
              tx_next = ball_pos_x;
              ty_next = ball_pos_y;
              if (!jump_ok) begin
                hit_next = 4'd1;
              end else begin
                hit_next = hit_reg + 4'd1;
                if (hit_reg + 4'd1 == ACQ_N) begin
                  state_next = S_TRACK;
                  lock_next  = 1'b1;
                  vx_next    = dx;
                  vy_next    = dy;
                end
              end
            end
          end
          default: begin
            if (det) begin
              // Re-acquire from coast without a jump test or lock pulse.
              state_next = S_TRACK;
              tx_next    = ball_pos_x;
              ty_next    = ball_pos_y;
              vx_next    = dx;
              vy_next    = dy;
              miss_next  = '0;
            end else begin
              miss_next  = (state_reg == S_TRACK) ? 4'd1 : miss_reg + 4'd1;
              state_next = S_COAST;
              if (miss_next == LOST_N) begin
                state_next = S_SEARCH;
                lost_next  = 1'b1;
                vx_next    = '0;
                vy_next    = '0;
                miss_next  = '0;
                hit_next   = '0;
              end
            end
          end
        endcase
      end else begin
        if (wd_reg < WD_MAX) wd_next = wd_reg + 1'b1;
        if (wd_next == WD_MAX) begin
          stale_next = 1'b1;
          state_next = S_SEARCH;
          hit_next   = '0;
          miss_next  = '0;
          vx_next    = '0;
          vy_next    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= S_SEARCH;
      tx_reg    <= '0;
      ty_reg    <= '0;
      vx_reg    <= '0;
      vy_reg    <= '0;
      hit_reg   <= '0;
      miss_reg  <= '0;
      wd_reg    <= '0;
      stale_reg <= 1'b0;
      lock_reg  <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tx_reg    <= tx_next;
      ty_reg    <= ty_next;
      vx_reg    <= vx_next;
      vy_reg    <= vy_next;
      hit_reg   <= hit_next;
      miss_reg  <= miss_next;
      wd_reg    <= wd_next;
      stale_reg <= stale_next;
      lock_reg  <= lock_next;
      lost_reg  <= lost_next;
    end
  end

  assign track_state = state_reg;
  assign target_x    = tx_reg;
  assign target_y    = ty_reg;
  assign vel_x       = vx_reg;
  assign vel_y       = vy_reg;
  assign lock        = lock_reg;
  assign lost        = lost_reg;
  assign stale       = stale_reg;

  always_comb begin
    steer_left  = 1'b0;
    steer_right = 1'b0;
    drive_fwd   = 1'b0;
    if (run && !stale_reg) begin
      case (state_reg)
        S_SEARCH: steer_right = 1'b1;
        S_ACQ:    ;
        default: begin
          if ($signed({1'b0, tx_reg}) < LEFT_TH)       steer_left  = 1'b1;
          else if ($signed({1'b0, tx_reg}) > RIGHT_TH) steer_right = 1'b1;
          else                                         drive_fwd   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_tracker.sv
// Self-checking bench for ball_tracker: directed test-plan scenarios with
// literal expectations, then randomized frames against a behavioural model.
module tb_ball_tracker;
  localparam int ACQ_FRAMES  = 3;
  localparam int LOST_FRAMES = 4;
  localparam int JUMP_MAX    = 2;
  localparam int CENTER_X    = 4;
  localparam int DEADBAND    = 1;
  localparam int TIMEOUT     = 255;

  logic clk = 1'b0;
  logic n_rst, clk_en, run, frame_valid, ball_detected;
  logic [3:0] ball_pos_x, ball_pos_y;
  logic [1:0] track_state;
  logic [3:0] target_x, target_y;
  logic [4:0] vel_x, vel_y;
  logic lock, lost, stale, steer_left, steer_right, drive_fwd;

  always #5 clk = ~clk;

  ball_tracker #(
    .ACQ_FRAMES(ACQ_FRAMES), .LOST_FRAMES(LOST_FRAMES), .JUMP_MAX(JUMP_MAX),
    .CENTER_X(CENTER_X), .DEADBAND(DEADBAND), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .run(run),
    .frame_valid(frame_valid), .ball_detected(ball_detected),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .track_state(track_state), .target_x(target_x), .target_y(target_y),
    .vel_x(vel_x), .vel_y(vel_y), .lock(lock), .lost(lost), .stale(stale),
    .steer_left(steer_left), .steer_right(steer_right), .drive_fwd(drive_fwd)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state (plain integers, expected post-edge values).
  int m_state, m_tx, m_ty, m_vx, m_vy, m_hit, m_miss, m_wd;
  int m_stale, m_lock, m_lost;
  int rx, ry;

  task automatic model_reset();
    m_state = 0; m_tx = 0; m_ty = 0; m_vx = 0; m_vy = 0;
    m_hit = 0; m_miss = 0; m_wd = 0; m_stale = 0; m_lock = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit en, input bit fv, input bit det_in,
                            input int x, input int y);
    bit ok;
    int dx, dy;
    m_lock = 0;
    m_lost = 0;
    if (en && !fv) begin
      if (m_wd < TIMEOUT) m_wd = m_wd + 1;
      if (m_wd == TIMEOUT) begin
        m_stale = 1; m_state = 0; m_hit = 0; m_miss = 0; m_vx = 0; m_vy = 0;
      end
    end else if (en && fv) begin
      m_wd = 0;
      m_stale = 0;
      ok = det_in && (x <= 7) && (y <= 4);
      dx = x - m_tx;
      dy = y - m_ty;
      if (m_state == 0) begin
        if (ok) begin
          m_state = 1; m_hit = 1; m_tx = x; m_ty = y; m_vx = 0; m_vy = 0;
        end
      end else if (m_state == 1) begin
        if (!ok) begin
          m_state = 0; m_hit = 0;
        end else begin
          m_tx = x; m_ty = y;
          if (dx > JUMP_MAX || -dx > JUMP_MAX || dy > JUMP_MAX || -dy > JUMP_MAX)
            m_hit = 1;
          else begin
            m_hit = m_hit + 1;
            if (m_hit == ACQ_FRAMES) begin
              m_state = 2; m_lock = 1; m_vx = dx; m_vy = dy;
            end
          end
        end
      end else begin
        if (ok) begin
          m_state = 2; m_vx = dx; m_vy = dy; m_tx = x; m_ty = y; m_miss = 0;
        end else begin
          m_miss = (m_state == 2) ? 1 : m_miss + 1;
          m_state = 3;
          if (m_miss == LOST_FRAMES) begin
            m_state = 0; m_lost = 1; m_vx = 0; m_vy = 0; m_miss = 0; m_hit = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int el, er, ef;
    el = 0; er = 0; ef = 0;
    if (run && m_stale == 0) begin
      if (m_state == 0) er = 1;
      else if (m_state >= 2) begin
        if (m_tx < CENTER_X - DEADBAND)      el = 1;
        else if (m_tx > CENTER_X + DEADBAND) er = 1;
        else                                 ef = 1;
      end
    end
    vectors++;
    chk("track_state", int'(track_state), m_state);
    chk("target_x", int'(target_x), m_tx);
    chk("target_y", int'(target_y), m_ty);
    chk("vel_x", int'($signed(vel_x)), m_vx);
    chk("vel_y", int'($signed(vel_y)), m_vy);
    chk("lock", int'(lock), m_lock);
    chk("lost", int'(lost), m_lost);
    chk("stale", int'(stale), m_stale);
    chk("steer_left", int'(steer_left), el);
    chk("steer_right", int'(steer_right), er);
    chk("drive_fwd", int'(drive_fwd), ef);
  endtask

  // Apply one cycle of inputs at a negedge, then check at the next negedge.
  task automatic cyc(input bit en, input bit r, input bit fv, input bit det,
                     input int x, input int y);
    clk_en = en; run = r; frame_valid = fv; ball_detected = det;
    ball_pos_x = 4'(x); ball_pos_y = 4'(y);
    model_step(en, fv, det, x, y);
    @(negedge clk);
    check_all();
  endtask

  task automatic frame(input bit det, input int x, input int y);
    cyc(1'b1, 1'b1, 1'b1, det, x, y);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_state", int'(track_state), 0);
    chk("rst_lock", int'(lock), 0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0; clk_en = 1'b0; run = 1'b0; frame_valid = 1'b0;
    ball_detected = 1'b0; ball_pos_x = 4'd0; ball_pos_y = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_state", int'(track_state), 0);
    chk("reset_vel_x", int'(vel_x), 0);
    n_rst = 1'b1;

    // Idle with run high: search spin; run low silences commands.
    idle();
    chk("idle_steer_right", int'(steer_right), 1);
    chk("idle_drive_fwd", int'(drive_fwd), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("run0_steer_right", int'(steer_right), 0);

    // Acquisition to lock.
    frame(1'b1, 5, 2); chk("acq1_state", int'(track_state), 1);
    frame(1'b1, 5, 2); chk("acq2_state", int'(track_state), 1);
    frame(1'b1, 6, 2);
    chk("lock_state", int'(track_state), 2);
    chk("lock_pulse", int'(lock), 1);
    chk("lock_tx", int'(target_x), 6);
    chk("lock_vx", int'($signed(vel_x)), 1);
    chk("lock_right", int'(steer_right), 1);
    idle();
    chk("lock_one_cycle", int'(lock), 0);

    // Jump rejection during acquisition.
    do_reset();
    frame(1'b1, 1, 1);
    frame(1'b1, 6, 1);
    chk("jump_state", int'(track_state), 1);
    chk("jump_tx", int'(target_x), 6);
    frame(1'b1, 6, 1);
    frame(1'b1, 6, 1);
    chk("jump_locked", int'(track_state), 2);

    // Tracking velocity and steering.
    frame(1'b1, 4, 3);
    frame(1'b1, 2, 3);
    chk("trk_vx_neg", int'($signed(vel_x)), -2);
    chk("trk_vy", int'($signed(vel_y)), 0);
    chk("trk_left", int'(steer_left), 1);
    frame(1'b1, 4, 3);
    chk("trk_vx_pos", int'($signed(vel_x)), 2);
    chk("trk_fwd", int'(drive_fwd), 1);

    // Coast and loss.
    frame(1'b0, 0, 0);
    chk("coast_state", int'(track_state), 3);
    chk("coast_tx", int'(target_x), 4);
    chk("coast_ty", int'(target_y), 3);
    frame(1'b0, 0, 0);
    frame(1'b0, 0, 0);
    chk("coast3_lost", int'(lost), 0);
    frame(1'b0, 0, 0);
    chk("lost_pulse", int'(lost), 1);
    chk("lost_state", int'(track_state), 0);
    chk("lost_vx", int'(vel_x), 0);

    // Re-acquire and recover from coast.
    frame(1'b1, 4, 3); frame(1'b1, 4, 3); frame(1'b1, 4, 3);
    frame(1'b0, 0, 0);
    frame(1'b1, 5, 3);
    chk("recover_state", int'(track_state), 2);
    chk("recover_nolock", int'(lock), 0);

    // Watchdog boundary.
    repeat (TIMEOUT - 1) idle();
    chk("wd_254_stale", int'(stale), 0);
    chk("wd_254_state", int'(track_state), 2);
    idle();
    chk("wd_stale", int'(stale), 1);
    chk("wd_state", int'(track_state), 0);
    chk("wd_cmd", int'(steer_right), 0);
    frame(1'b1, 3, 0);
    chk("wd_clear", int'(stale), 0);
    chk("wd_acq", int'(track_state), 1);

    // Randomized phase.
    rx = 4; ry = 2;
    for (int i = 0; i < 3000; i++) begin
      bit en, r, fv, det;
      if (i == 1500) do_reset();
      en  = ($urandom % 10) != 0;
      r   = ($urandom % 8) != 0;
      fv  = (i >= 2000 && i < 2300) ? 1'b0 : (($urandom % 3) == 0);
      det = ($urandom % 5) != 0;
      if ($urandom % 4 == 0) begin
        rx = $urandom % 10;
        ry = $urandom % 6;
      end else begin
        rx = rx + int'($urandom % 3) - 1;
        ry = ry + int'($urandom % 3) - 1;
        if (rx < 0) rx = 0;
        if (rx > 9) rx = 9;
        if (ry < 0) ry = 0;
        if (ry > 5) ry = 5;
      end
      cyc(en, r, fv, det, rx, ry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ball_tracker.md
Name: ball_tracker

Overview:
- Downstream consumer of the IR sensor-array scanner (5 rows x 8 columns).
- Takes one ball position and detect flag per completed scan frame.
- Debounces acquisition, rejects implausible jumps and coasts through short dropouts.
- Computes per-frame velocity, runs a frame-rate watchdog, and issues left / right / forward steering commands to the drive controller.

Parameters:
- ACQ_FRAMES, 3: consecutive consistent detections needed to lock (legal range 2..15).
- LOST_FRAMES, 4: consecutive misses in coast before declaring loss (legal range 1..15).
- JUMP_MAX, 2: maximum per-axis position change accepted during acquisition.
- CENTER_X, 4: steering centre column.
- DEADBAND, 1: half-width of the forward band around CENTER_X.
- TIMEOUT, 255: clk_en cycles without a frame before the stale fault.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; all state advances only when high
- run  in  1  command enable; low forces all steer/drive outputs to 0 (tracking continues)
- frame_valid  in  1  one-clk_en-cycle strobe: ball_detected and the position inputs hold a new frame
- ball_detected  in  1  frame contains an active sensor
- ball_pos_x  in  4  column 0..7
- ball_pos_y  in  4  row 0..4
- track_state  out  2  0 SEARCH, 1 ACQUIRE, 2 TRACK, 3 COAST
- target_x  out  4  filtered column
- target_y  out  4  filtered row
- vel_x  out  5  signed per-frame x delta
- vel_y  out  5  signed per-frame y delta
- lock  out  1  one-cycle pulse on entry to TRACK from ACQUIRE
- lost  out  1  one-cycle pulse on COAST->SEARCH by miss count
- stale  out  1  watchdog fault flag
- steer_left  out  1  turn-left command
- steer_right  out  1  turn-right command
- drive_fwd  out  1  forward command

Behaviour:
- Interface: reset n_rst, asynchronous, active-low; clock clk.
- Reset values: state SEARCH; target 0,0; vel 0,0; hit_cnt, miss_cnt and watchdog counter 0; lock, lost, stale 0.
- Frame event: clk_en && frame_valid. frame_valid with clk_en low is ignored. With clk_en low, no register changes and pulses do not extend.
- Timing: every state, target and vel update is registered and visible the clock after the frame event (1-cycle latency).
- dx = ball_pos_x - target_x and dy = ball_pos_y - target_y, computed as 5-bit signed. Jump test: |dx| <= JUMP_MAX and |dy| <= JUMP_MAX.
- SEARCH, on a frame:
  - detected: go to ACQUIRE, hit_cnt=1, target=pos, vel=0.
  - undetected: stay.
- ACQUIRE, on a frame:
  - undetected: go to SEARCH, hit_cnt=0.
  - detected and jump test fails: hit_cnt=1, target=pos, stay.
  - detected and jump test passes: target=pos, hit_cnt+1. If hit_cnt+1 == ACQ_FRAMES, go to TRACK, pulse lock, vel=dx,dy.
- TRACK, on a frame:
  - detected: vel=dx,dy, target=pos, miss_cnt=0.
  - undetected: go to COAST, miss_cnt=1, target and vel held. If LOST_FRAMES==1, go straight to SEARCH and pulse lost instead.
- COAST, on a frame:
  - detected: go to TRACK, vel=dx,dy, target=pos, miss_cnt=0. No jump test; no lock pulse.
  - undetected: miss_cnt+1. If miss_cnt+1 == LOST_FRAMES, go to SEARCH, pulse lost, vel=0, miss_cnt=0.
- Watchdog:
  - Counter increments on each clk_en cycle without a frame event and saturates at TIMEOUT.
  - Reaching TIMEOUT sets stale and forces SEARCH, with hit_cnt, miss_cnt and vel cleared and target held. No lost pulse.
  - A frame event clears the counter and stale. That same frame is processed from SEARCH.
  - Expiry coincident with a frame event: the frame wins and stale is not set.
- Commands: combinational from registered state and target; all 0 when run=0 or stale=1.
  - SEARCH: steer_right=1 (search spin).
  - ACQUIRE: all 0.
  - TRACK and COAST: steer_left if target_x < CENTER_X-DEADBAND; steer_right if target_x > CENTER_X+DEADBAND; otherwise drive_fwd. Exactly one is high.
- Signed compare: comparisons use 5-bit signed arithmetic so CENTER_X-DEADBAND below 0 never matches.
- Out-of-range input: ball_pos_y > 4 or ball_pos_x > 7 with detected=1 is treated as undetected.
- Reset mid-operation: asynchronously returns everything to reset values, including pulses.

Test Plan:
- Reset, then run=1 with no frames: state 0, steer_right=1, drive_fwd=0, all pulses 0; with run=0, all commands 0.
- Frames detected at (5,2),(5,2),(6,2): state 1,1,2 after each; lock high for exactly one cycle after the third; target (6,2), vel_x=+1, steer_right=1.
- In ACQUIRE at (1,1), frame at (6,1): hit_cnt=1, state stays 1, target (6,1); two more frames at (6,1) then reach TRACK.
- In TRACK at (4,3), frame at (2,3) -> vel_x=-2, vel_y=0, target_x=2, steer_left=1; next frame at (4,3) -> vel_x=+2, drive_fwd=1.
- In TRACK at (4,3), four undetected frames: state 3 after the first, target held (4,3); lost pulse and state 0 after the fourth, vel 0; a detected frame during coast returns to 2 with no lock pulse.
- In TRACK, hold frame_valid low for 255 clk_en cycles: stale=1, state 0, commands 0; next frame (detected at (3,0)) clears stale, state 1.
